eth_rx_mac_filter: RTL and testbench
====================================

Name: eth_rx_mac_filter

Overview:
- Receive-side destination-MAC filter in the logic clock domain, directly downstream of the 10G MAC RX FIFO AXI-stream output.
- Inspects the first beat of each frame and either forwards or silently discards the whole frame.
- Accept rules: unicast match against a configured address, broadcast, multicast, or promiscuous mode.
- Forwarded frames pass through a single registered output stage to the user logic.

Parameters:
- DATA_WIDTH, 64, AXI-stream data width; only 64 is supported (elaboration error otherwise).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width; carried through unmodified (bit 0 = bad-frame flag).

Ports:
- clk  in  1  logic clock.
- rst  in  1  asynchronous active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input data; byte 0 = tdata[7:0] = first byte on wire.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tuser  in  USER_WIDTH  input user.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tuser  out  USER_WIDTH  output user.
- cfg_mac_addr  in  48  station address; [47:40] is the first byte on the wire.
- cfg_promisc  in  1  accept all frames.
- cfg_bcast_en  in  1  accept FF:FF:FF:FF:FF:FF.
- cfg_mcast_en  in  1  accept group addresses (byte0 bit0 = 1).
- status_frame_pass  out  1  one-cycle pulse when a frame is accepted for forwarding.
- status_frame_drop  out  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values: state=FIRST; m_axis_tvalid=0; m_axis_tdata/tkeep/tlast/tuser=0; status pulses=0.
- Reset is asynchronous. Reset mid-frame: state returns to FIRST and the next accepted beat is treated as a frame start, since upstream is reset together.
- Destination MAC: dmac = {tdata[7:0], tdata[15:8], tdata[23:16], tdata[31:24], tdata[39:32], tdata[47:40]}.
- States: FIRST, PASS, DROP.
  - FIRST: the beat is evaluated only when s_axis_tvalid && s_axis_tready. cfg_* is sampled on that beat only; later cfg changes do not affect the frame in flight.
  - Accept when: cfg_promisc; or dmac==cfg_mac_addr; or (dmac==all-ones && cfg_bcast_en); or (dmac!=all-ones && dmac[40] && cfg_mcast_en). Broadcast is not covered by cfg_mcast_en.
  - Runt: first beat has tlast with fewer than 6 valid bytes (tkeep[5:0]!=6'h3F). Always dropped, even in promiscuous mode.
  - Accept: beat is forwarded, status_frame_pass pulses the following cycle; next state PASS, or stay FIRST if tlast.
  - Reject: beat is discarded, status_frame_drop pulses the following cycle; next state DROP, or stay FIRST if tlast.
  - PASS: beats are forwarded; tlast returns to FIRST.
  - DROP: s_axis_tready=1 unconditionally; beats discarded; tlast returns to FIRST.
- Output register: in FIRST/PASS, s_axis_tready = m_axis_tready || !m_axis_tvalid.
  - Latency from accepted input beat to m_axis_tvalid is 1 cycle.
  - Throughput is 1 beat/cycle while m_axis_tready=1.
  - m_axis_* stays stable while tvalid && !tready.
  - Simultaneous output drain and input load in the same cycle is required (no bubble).
- A dropped beat never asserts m_axis_tvalid. Back-to-back frames (tlast then the next first beat on consecutive cycles) are required, with no idle cycle.
- tuser is not used for filtering; bad frames are forwarded or dropped purely on address.

Optional Feature:
- Macro: ETH_RX_MAC_FILTER_STATS_EN.
- When defined, adds ports stat_pass_count out 32 and stat_drop_count out 32.
  - Reset value 0.
  - Increment on the same cycle as the corresponding status pulse.
  - Saturate at 32'hFFFFFFFF; no wrap.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package eth_rx_filter_pkg holds:
  - state encoding (FIRST=2'd0, PASS=2'd1, DROP=2'd2);
  - ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  - ETH_MIN_HDR_BYTES = 6.
- One sub-module: eth_rx_filter_out_reg, a single-entry AXI-stream register slice holding data/keep/last/user with valid/ready. The top level holds the state machine, match logic and optional counters.

Test Plan:
- Unicast match: cfg_mac_addr=48'h02_00_00_00_00_01; 3-beat frame with tdata[47:0]=48'h01_00_00_00_00_02 -> all 3 beats on m_axis 1 cycle later, identical; status_frame_pass=1 once.
- Unicast miss: same cfg; dmac 02:00:00:00:00:09, 4 beats, cfg_promisc=0 -> m_axis_tvalid stays 0; s_axis_tready=1 for beats 2-4; status_frame_drop=1 once.
- Broadcast/multicast gating: dmac FF:FF:FF:FF:FF:FF with cfg_bcast_en=0, cfg_mcast_en=1 -> dropped; dmac 01:00:5E:00:00:01 with cfg_mcast_en=1 -> passed.
- Runt and back-to-back: single beat tkeep=8'h0F, tlast=1, cfg_promisc=1 -> dropped. An immediately following matching 2-beat frame -> passed with no idle cycle.
- Backpressure: matching 8-beat frame, m_axis_tready toggled 1,0,0,1,...; mid-frame cfg_mac_addr change -> no beat lost or duplicated; output stable while stalled; frame still passed.
- Reset mid-frame: assert rst during beat 2 of a PASS frame -> m_axis_tvalid=0 immediately; after release, a new matching frame passes. With ETH_RX_MAC_FILTER_STATS_EN: counters reset to 0, and pass count is 1 after this frame.

Source files
------------

// File: rtl/eth_rx_filter_pkg.sv
// Shared definitions for the receive-side destination-MAC filter:
// filter state encoding, Ethernet address constants and a helper that
// extracts the destination MAC from the first 64-bit beat of a frame.
package eth_rx_filter_pkg;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2
  } filt_state_e;

  localparam logic [47:0] ETH_BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned ETH_MIN_HDR_BYTES = 6;

  // Byte 0 on the wire sits in bits [7:0] but is the most significant
  // byte of the address, so the six header bytes are reversed here.
  function automatic logic [47:0] dmac_from_beat(input logic [47:0] hdr);
    return {hdr[7:0], hdr[15:8], hdr[23:16], hdr[31:24], hdr[39:32], hdr[47:40]};
  endfunction

endpackage

// File: rtl/eth_rx_filter_out_reg.sv
// Single-entry AXI-stream register slice (data/keep/last/user + valid/ready).
// Accepts a new beat whenever the slice is empty or being drained in the
// same cycle, giving full throughput with no bubble.
module eth_rx_filter_out_reg #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [KEEP_WIDTH-1:0] s_keep_i,
  input  logic                  s_last_i,
  input  logic [USER_WIDTH-1:0] s_user_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [KEEP_WIDTH-1:0] m_keep_o,
  output logic                  m_last_o,
  output logic [USER_WIDTH-1:0] m_user_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [KEEP_WIDTH-1:0] keep_q;
  logic                  last_q;
  logic [USER_WIDTH-1:0] user_q;
  logic                  valid_q;

  assign s_ready_o = m_ready_i || !valid_q;

  // Load on input handshake, otherwise empty the slot when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      valid_q <= 1'b0;
    end else if (s_valid_i && s_ready_o) begin
      data_q  <= s_data_i;
      keep_q  <= s_keep_i;
      last_q  <= s_last_i;
      user_q  <= s_user_i;
      valid_q <= 1'b1;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;
  assign m_last_o  = last_q;
  assign m_user_o  = user_q;
  assign m_valid_o = valid_q;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Receive destination-MAC filter downstream of the 10G MAC RX FIFO.
// The first beat of each frame is checked against the unicast station
// address, broadcast, multicast and promiscuous settings; the whole frame
// is then forwarded through a register slice or silently discarded.
// Optional statistics counters: define ETH_RX_MAC_FILTER_STATS_EN.
module eth_rx_mac_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [47:0]           cfg_mac_addr,
  input  logic                  cfg_promisc,
  input  logic                  cfg_bcast_en,
  input  logic                  cfg_mcast_en,
  output logic                  status_frame_pass,
  output logic                  status_frame_drop
`ifdef ETH_RX_MAC_FILTER_STATS_EN
  ,
  output logic [31:0]           stat_pass_count,
  output logic [31:0]           stat_drop_count
`endif
);

  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("eth_rx_mac_filter: only DATA_WIDTH=64 is supported");
  end
  if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep
    $error("eth_rx_mac_filter: KEEP_WIDTH must equal DATA_WIDTH/8");
  end

  filt_state_e state_q, state_d;
  logic        pass_q, pass_d;
  logic        drop_q, drop_d;
  logic        load;
  logic        slice_ready;
  logic        beat;
  logic [47:0] dmac;
  logic        is_bcast;
  logic        is_runt;
  logic        addr_ok;
  logic        frame_ok;

  // Discarded frames are sunk at full rate regardless of the output side.
  assign s_axis_tready = (state_q == ST_DROP) || slice_ready;
  assign beat          = s_axis_tvalid && s_axis_tready;

  // Address decision; only consumed on the first beat, so cfg_* is
  // effectively sampled once per frame.
  assign dmac     = dmac_from_beat(s_axis_tdata[47:0]);
  assign is_bcast = (dmac == ETH_BCAST_ADDR);
  assign is_runt  = s_axis_tlast && (s_axis_tkeep[ETH_MIN_HDR_BYTES-1:0] != '1);
  assign addr_ok  = cfg_promisc
                 || (dmac == cfg_mac_addr)
                 || (is_bcast && cfg_bcast_en)
                 || (!is_bcast && dmac[40] && cfg_mcast_en);
  assign frame_ok = addr_ok && !is_runt;

  // Filter state register and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FIRST;
      pass_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, forward/discard decision and pulse requests.
  always_comb begin
    state_d = state_q;
    pass_d  = 1'b0;
    drop_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_FIRST: begin
        if (beat) begin
          if (frame_ok) begin
            load   = 1'b1;
            pass_d = 1'b1;
            if (!s_axis_tlast) state_d = ST_PASS;
          end else begin
            drop_d = 1'b1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (beat) begin
          load = 1'b1;
          if (s_axis_tlast) state_d = ST_FIRST;
        end
      end
      ST_DROP: begin
        if (beat && s_axis_tlast) state_d = ST_FIRST;
      end
      default: state_d = ST_FIRST;
    endcase
  end

  eth_rx_filter_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .s_data_i  (s_axis_tdata),
    .s_keep_i  (s_axis_tkeep),
    .s_last_i  (s_axis_tlast),
    .s_user_i  (s_axis_tuser),
    .s_valid_i (load),
    .s_ready_o (slice_ready),
    .m_data_o  (m_axis_tdata),
    .m_keep_o  (m_axis_tkeep),
    .m_last_o  (m_axis_tlast),
    .m_user_o  (m_axis_tuser),
    .m_valid_o (m_axis_tvalid),
    .m_ready_i (m_axis_tready)
  );

  assign status_frame_pass = pass_q;
  assign status_frame_drop = drop_q;

`ifdef ETH_RX_MAC_FILTER_STATS_EN
  logic [31:0] pass_cnt_q;
  logic [31:0] drop_cnt_q;

  // Saturating frame counters, updated on the edge that raises each pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pass_d && (pass_cnt_q != '1)) pass_cnt_q <= pass_cnt_q + 32'd1;
      if (drop_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign stat_pass_count = pass_cnt_q;
  assign stat_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed self-checking bench for eth_rx_mac_filter.
module tb_eth_rx_mac_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [0:0]  s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic [47:0] cfg_mac_addr;
  logic        cfg_promisc;
  logic        cfg_bcast_en;
  logic        cfg_mcast_en;
  logic        status_frame_pass;
  logic        status_frame_drop;
`ifdef ETH_RX_MAC_FILTER_STATS_EN
  logic [31:0] stat_pass_count;
  logic [31:0] stat_drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [47:0] STATION = 48'h02_00_00_00_00_01;

  // Frame stimulus table
  logic [63:0] tx_d [16];
  logic [7:0]  tx_k [16];
  logic        tx_l [16];
  logic        tx_u [16];
  int          tx_n;

  // Observations from the last run_frames call
  logic [63:0] cap_d [$];
  logic [7:0]  cap_k [$];
  logic        cap_l [$];
  logic        cap_u [$];
  int obs_pass, obs_drop, obs_unstable, obs_stall_in, obs_lat;
  bit obs_anyvalid;

  always #5 clk = ~clk;

  eth_rx_mac_filter #(
    .DATA_WIDTH(64),
    .KEEP_WIDTH(8),
    .USER_WIDTH(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tkeep      (s_axis_tkeep),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tuser      (s_axis_tuser),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tkeep      (m_axis_tkeep),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tuser      (m_axis_tuser),
    .cfg_mac_addr      (cfg_mac_addr),
    .cfg_promisc       (cfg_promisc),
    .cfg_bcast_en      (cfg_bcast_en),
    .cfg_mcast_en      (cfg_mcast_en),
    .status_frame_pass (status_frame_pass),
    .status_frame_drop (status_frame_drop)
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    ,
    .stat_pass_count   (stat_pass_count),
    .stat_drop_count   (stat_drop_count)
`endif
  );

  // First beat carrying the given destination MAC (first wire byte in [7:0]).
  function automatic logic [63:0] first_beat(input logic [47:0] mac, input logic [15:0] hi);
    return {hi, mac[7:0], mac[15:8], mac[23:16], mac[31:24], mac[39:32], mac[47:40]};
  endfunction

  task automatic set_beat(input int i, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic u);
    tx_d[i] = d; tx_k[i] = k; tx_l[i] = l; tx_u[i] = u;
  endtask

  // Fill a simple nb-beat frame starting at index base.
  task automatic build_frame(input int base, input logic [63:0] d0, input int nb,
                             input logic [7:0] last_keep);
    for (int i = 0; i < nb; i++) begin
      set_beat(base + i,
               (i == 0) ? d0 : (64'h0123_4567_89AB_CD00 + 64'(base * 16 + i)),
               (i == nb - 1) ? last_keep : 8'hFF,
               (i == nb - 1),
               (i == nb - 1));
    end
  endtask

  // Streams tx_d[0..tx_n-1] back to back and records what appears on m_axis.
  // mode 0: m_axis_tready held high; mode 1: ready pattern 1,0,0,1,...
  task automatic run_frames(input int mode, input int chg_cyc);
    int idx, c, idle, acc0, out0;
    logic stall;
    logic [63:0] pd;
    logic [7:0] pk;
    logic pl, pu;
    idx = 0; c = 0; idle = 0; acc0 = -1; out0 = -1; stall = 1'b0;
    pd = '0; pk = '0; pl = 1'b0; pu = 1'b0;
    cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_u.delete();
    obs_pass = 0; obs_drop = 0; obs_unstable = 0; obs_stall_in = 0; obs_anyvalid = 0;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (c == chg_cyc) cfg_mac_addr = 48'h0A_0B_0C_0D_0E_0F;
      if (idx < tx_n) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = tx_d[idx];
        s_axis_tkeep  = tx_k[idx];
        s_axis_tlast  = tx_l[idx];
        s_axis_tuser  = tx_u[idx];
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
      end
      @(negedge clk);
      if (stall && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tkeep !== pk ||
                    m_axis_tlast !== pl || m_axis_tuser[0] !== pu))
        obs_unstable++;
      stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast; pu = m_axis_tuser[0];
      if (m_axis_tvalid) begin
        obs_anyvalid = 1'b1;
        if (out0 < 0) out0 = c;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap_d.push_back(m_axis_tdata);
        cap_k.push_back(m_axis_tkeep);
        cap_l.push_back(m_axis_tlast);
        cap_u.push_back(m_axis_tuser[0]);
      end
      if (status_frame_pass) obs_pass++;
      if (status_frame_drop) obs_drop++;
      if (s_axis_tvalid && !s_axis_tready) obs_stall_in++;
      if (s_axis_tvalid && s_axis_tready) begin
        if (acc0 < 0) acc0 = c;
        idx++;
      end
      if (idx >= tx_n && !m_axis_tvalid) idle++;
      if (idle >= 3) break;
      c++;
      if (c > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL run_timeout: sent %0d of %0d beats within 300 cycles", idx, tx_n);
        break;
      end
    end
    obs_lat = (out0 >= 0) ? (out0 - acc0) : -1;
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0; m_axis_tready = 1'b1;
    cfg_mac_addr = STATION; cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== 64'h0) begin n_bad++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 8'h0) begin n_bad++; $display("FAIL rst_tkeep: got %h want 0", m_axis_tkeep); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tuser !== 1'b0) begin n_bad++; $display("FAIL rst_tuser: got %b want 0", m_axis_tuser); end
    n_cmp++; if (status_frame_pass !== 1'b0 || status_frame_drop !== 1'b0) begin
      n_bad++; $display("FAIL rst_status: got pass=%b drop=%b want 0/0", status_frame_pass, status_frame_drop); end
    n_cmp++; if (s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL rst_tready: got %b want 1", s_axis_tready); end
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    n_cmp++; if (stat_pass_count !== 32'd0 || stat_drop_count !== 32'd0) begin
      n_bad++; $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_pass_count, stat_drop_count); end
`endif
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_unicast_match();
    cfg_mac_addr = STATION; cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    tx_n = 3;
    build_frame(0, {16'hAAAA, 48'h01_00_00_00_00_02}, 3, 8'h1F);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 3) begin n_bad++; $display("FAIL uc_beats: got %0d want 3", cap_d.size()); end
    for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== tx_d[i] || cap_k[i] !== tx_k[i] || cap_l[i] !== tx_l[i] || cap_u[i] !== tx_u[i]) begin
        n_bad++;
        $display("FAIL uc_beat%0d: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 cap_d[i], cap_k[i], cap_l[i], cap_u[i], tx_d[i], tx_k[i], tx_l[i], tx_u[i]);
      end
    end
    n_cmp++; if (obs_lat !== 1) begin n_bad++; $display("FAIL uc_latency: got %0d want 1", obs_lat); end
    n_cmp++; if (obs_pass !== 1 || obs_drop !== 0) begin
      n_bad++; $display("FAIL uc_status: got pass=%0d drop=%0d want 1/0", obs_pass, obs_drop); end
    n_cmp++; if (obs_stall_in !== 0) begin n_bad++; $display("FAIL uc_throughput: got %0d stalls want 0", obs_stall_in); end
  endtask

  task automatic test_unicast_miss();
    cfg_mac_addr = STATION; cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    tx_n = 4;
    build_frame(0, {16'hBBBB, 48'h09_00_00_00_00_02}, 4, 8'hFF);
    run_frames(0, -1);
    n_cmp++; if (obs_anyvalid !== 1'b0) begin n_bad++; $display("FAIL miss_tvalid: got 1 want 0"); end
    n_cmp++; if (obs_stall_in !== 0) begin n_bad++; $display("FAIL miss_tready: got %0d stalls want 0", obs_stall_in); end
    n_cmp++; if (obs_pass !== 0 || obs_drop !== 1) begin
      n_bad++; $display("FAIL miss_status: got pass=%0d drop=%0d want 0/1", obs_pass, obs_drop); end
  endtask

  task automatic test_bcast_mcast();
    cfg_mac_addr = STATION; cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b1;
    tx_n = 2;
    build_frame(0, {16'hCCCC, 48'hFF_FF_FF_FF_FF_FF}, 2, 8'hFF);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 0 || obs_drop !== 1 || obs_pass !== 0) begin
      n_bad++; $display("FAIL bcast_off: got beats=%0d pass=%0d drop=%0d want 0/0/1", cap_d.size(), obs_pass, obs_drop); end
    build_frame(0, {16'hCCCD, 48'h01_00_00_5E_00_01}, 2, 8'hFF);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 2 || obs_pass !== 1 || obs_drop !== 0) begin
      n_bad++; $display("FAIL mcast_on: got beats=%0d pass=%0d drop=%0d want 2/1/0", cap_d.size(), obs_pass, obs_drop); end
    cfg_mcast_en = 1'b0;
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 0 || obs_drop !== 1) begin
      n_bad++; $display("FAIL mcast_off: got beats=%0d drop=%0d want 0/1", cap_d.size(), obs_drop); end
    cfg_bcast_en = 1'b1;
    build_frame(0, {16'hCCCE, 48'hFF_FF_FF_FF_FF_FF}, 2, 8'hFF);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 2 || obs_pass !== 1) begin
      n_bad++; $display("FAIL bcast_on: got beats=%0d pass=%0d want 2/1", cap_d.size(), obs_pass); end
    cfg_bcast_en = 1'b0;
  endtask

  task automatic test_runt_back_to_back();
    cfg_mac_addr = STATION; cfg_promisc = 1'b1; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    tx_n = 3;
    set_beat(0, first_beat(48'h02_00_00_00_00_09, 16'h0000), 8'h0F, 1'b1, 1'b0);
    build_frame(1, first_beat(STATION, 16'hDDDD), 2, 8'h07);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 2) begin n_bad++; $display("FAIL b2b_beats: got %0d want 2", cap_d.size()); end
    for (int i = 0; i < 2 && i < cap_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== tx_d[i+1] || cap_k[i] !== tx_k[i+1] || cap_l[i] !== tx_l[i+1]) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_d[i], cap_k[i], cap_l[i], tx_d[i+1], tx_k[i+1], tx_l[i+1]);
      end
    end
    n_cmp++; if (obs_pass !== 1 || obs_drop !== 1) begin
      n_bad++; $display("FAIL b2b_status: got pass=%0d drop=%0d want 1/1", obs_pass, obs_drop); end
    n_cmp++; if (obs_stall_in !== 0) begin n_bad++; $display("FAIL b2b_idle: got %0d stalls want 0", obs_stall_in); end
    // Exactly six valid bytes on a single-beat frame is not a runt.
    tx_n = 1;
    set_beat(0, first_beat(48'h02_00_00_00_00_09, 16'h0000), 8'h3F, 1'b1, 1'b1);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 1 || obs_pass !== 1 || obs_drop !== 0) begin
      n_bad++; $display("FAIL runt_edge: got beats=%0d pass=%0d drop=%0d want 1/1/0", cap_d.size(), obs_pass, obs_drop); end
    cfg_promisc = 1'b0;
  endtask

  task automatic test_backpressure();
    cfg_mac_addr = STATION; cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    tx_n = 8;
    build_frame(0, first_beat(STATION, 16'hEEEE), 8, 8'h3F);
    run_frames(1, 3);
    n_cmp++; if (cap_d.size() !== 8) begin n_bad++; $display("FAIL bp_beats: got %0d want 8", cap_d.size()); end
    for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
      n_cmp++;
      if (cap_d[i] !== tx_d[i] || cap_k[i] !== tx_k[i] || cap_l[i] !== tx_l[i]) begin
        n_bad++;
        $display("FAIL bp_beat%0d: got %h/%h/%b want %h/%h/%b", i,
                 cap_d[i], cap_k[i], cap_l[i], tx_d[i], tx_k[i], tx_l[i]);
      end
    end
    n_cmp++; if (obs_unstable !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes want 0", obs_unstable); end
    n_cmp++; if (obs_pass !== 1 || obs_drop !== 0) begin
      n_bad++; $display("FAIL bp_status: got pass=%0d drop=%0d want 1/0", obs_pass, obs_drop); end
    cfg_mac_addr = STATION;
  endtask

  task automatic test_reset_mid_frame();
    cfg_mac_addr = STATION; cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_en = 1'b0;
    m_axis_tready = 1'b1;
    build_frame(0, first_beat(STATION, 16'hF00D), 4, 8'hFF);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = tx_d[0]; s_axis_tkeep = tx_k[0];
    s_axis_tlast = tx_l[0]; s_axis_tuser = tx_u[0];
    @(posedge clk); #1;
    s_axis_tdata = tx_d[1]; s_axis_tkeep = tx_k[1]; s_axis_tlast = tx_l[1];
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== tx_d[0]) begin
      n_bad++; $display("FAIL mr_pre: got v=%b d=%h want 1/%h", m_axis_tvalid, m_axis_tdata, tx_d[0]); end
    @(posedge clk); #1;
    s_axis_tdata = tx_d[2]; s_axis_tkeep = tx_k[2]; s_axis_tlast = tx_l[2];
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL mr_tvalid: got %b want 0", m_axis_tvalid); end
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    n_cmp++; if (stat_pass_count !== 32'd0 || stat_drop_count !== 32'd0) begin
      n_bad++; $display("FAIL mr_stats_rst: got %0d/%0d want 0/0", stat_pass_count, stat_drop_count); end
`endif
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // A non-matching frame must be judged as a new frame, not forwarded.
    tx_n = 2;
    build_frame(0, first_beat(48'h02_00_00_00_00_09, 16'h1234), 2, 8'hFF);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 0 || obs_drop !== 1) begin
      n_bad++; $display("FAIL mr_newframe_drop: got beats=%0d drop=%0d want 0/1", cap_d.size(), obs_drop); end
    build_frame(0, first_beat(STATION, 16'h5678), 2, 8'hFF);
    run_frames(0, -1);
    n_cmp++; if (cap_d.size() !== 2 || obs_pass !== 1) begin
      n_bad++; $display("FAIL mr_newframe_pass: got beats=%0d pass=%0d want 2/1", cap_d.size(), obs_pass); end
`ifdef ETH_RX_MAC_FILTER_STATS_EN
    n_cmp++; if (stat_pass_count !== 32'd1 || stat_drop_count !== 32'd1) begin
      n_bad++; $display("FAIL mr_stats: got %0d/%0d want 1/1", stat_pass_count, stat_drop_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_unicast_match();
    test_unicast_miss();
    test_bcast_mcast();
    test_runt_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
